// File: rtl/conv_1st_loader.sv
// First-layer convolution loader: streams biases then 4-per-word packed pixels
// onto pointer-addressed write buses, then pulses sta_o to the convolution block.
module conv_1st_loader #(
  parameter int         NUM_PIX   = 300,
  parameter int         NUM_BIAS  = 34,
  parameter logic [6:0] SCAN_IDLE = 7'h7F,
  parameter logic [5:0] BIAS_IDLE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  pix_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [15:0] bias_data_i,
  input  logic        bias_valid_i,
  output logic        bias_ready_o,
  output logic [39:0] scan_o,
  output logic [23:0] bias_o,
  output logic        busy_o,
  output logic        sta_o
);

  if ((NUM_PIX % 4) != 0) begin : g_bad_num_pix
    $error("conv_1st_loader: NUM_PIX must be a multiple of 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_BIAS = 2'd1,
    ST_LOAD_PIX  = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [39:0] SCAN_IDLE_WORD = {32'd0, 1'b0, SCAN_IDLE};
  localparam logic [23:0] BIAS_IDLE_WORD = {16'd0, 2'b00, BIAS_IDLE};
  localparam logic [5:0]  LAST_BIAS      = 6'(NUM_BIAS - 1);
  localparam logic [8:0]  LAST_PIX       = 9'(NUM_PIX - 1);

  state_t      state_r, state_s;
  logic [5:0]  bias_cnt_r, bias_cnt_s;
  logic [8:0]  pix_cnt_r, pix_cnt_s;
  logic [23:0] word_r, word_s;
  logic [39:0] scan_r, scan_s;
  logic [23:0] bias_r, bias_s;
  logic        sta_r, sta_s;
  logic        bias_hs_s, pix_hs_s;

  // Readies depend on state only; abort blocks acceptance in its own cycle.
  assign bias_ready_o = (state_r == ST_LOAD_BIAS) && !abort_i;
  assign pix_ready_o  = (state_r == ST_LOAD_PIX) && !abort_i;
  assign bias_hs_s    = bias_valid_i && bias_ready_o;
  assign pix_hs_s     = pix_valid_i && pix_ready_o;

  assign scan_o = scan_r;
  assign bias_o = bias_r;
  assign sta_o  = sta_r;
  assign busy_o = (state_r != ST_IDLE);

  // Next-state, counter, packing and write-word logic.
  always_comb begin
    state_s    = state_r;
    bias_cnt_s = bias_cnt_r;
    pix_cnt_s  = pix_cnt_r;
    word_s     = word_r;
    scan_s     = SCAN_IDLE_WORD;
    bias_s     = BIAS_IDLE_WORD;
    sta_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_LOAD_BIAS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_BIAS: begin
        if (abort_i) begin
          state_s    = ST_IDLE;
          bias_cnt_s = 6'd0;
          pix_cnt_s  = 9'd0;
          word_s     = 24'd0;
        end else if (bias_hs_s) begin
          bias_s = {bias_data_i, 2'b00, bias_cnt_r};
          if (bias_cnt_r == LAST_BIAS) begin
            bias_cnt_s = 6'd0;
            state_s    = ST_LOAD_PIX;
          end else begin
            bias_cnt_s = bias_cnt_r + 6'd1;
          end
        end else begin
          state_s = ST_LOAD_BIAS;
        end
      end
      ST_LOAD_PIX: begin
        if (abort_i) begin
          state_s    = ST_IDLE;
          bias_cnt_s = 6'd0;
          pix_cnt_s  = 9'd0;
          word_s     = 24'd0;
        end else if (pix_hs_s) begin
          // Lane 3 completes the word; lanes 0-2 are held in word_r meanwhile.
          case (pix_cnt_r[1:0])
            2'd0:    word_s[7:0]   = pix_i;
            2'd1:    word_s[15:8]  = pix_i;
            2'd2:    word_s[23:16] = pix_i;
            2'd3: begin
              scan_s = {pix_i, word_r, 1'b0, pix_cnt_r[8:2]};
              word_s = 24'd0;
            end
            default: word_s = 24'd0;
          endcase
          if (pix_cnt_r == LAST_PIX) begin
            pix_cnt_s = 9'd0;
            state_s   = ST_DONE;
          end else begin
            pix_cnt_s = pix_cnt_r + 9'd1;
          end
        end else begin
          state_s = ST_LOAD_PIX;
        end
      end
      ST_DONE: begin
        state_s    = ST_IDLE;
        bias_cnt_s = 6'd0;
        pix_cnt_s  = 9'd0;
        word_s     = 24'd0;
        sta_s      = !abort_i;
      end
      default: begin
        state_s    = ST_IDLE;
        bias_cnt_s = 6'd0;
        pix_cnt_s  = 9'd0;
        word_s     = 24'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      bias_cnt_r <= 6'd0;
      pix_cnt_r  <= 9'd0;
      word_r     <= 24'd0;
      scan_r     <= SCAN_IDLE_WORD;
      bias_r     <= BIAS_IDLE_WORD;
      sta_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      bias_cnt_r <= bias_cnt_s;
      pix_cnt_r  <= pix_cnt_s;
      word_r     <= word_s;
      scan_r     <= scan_s;
      bias_r     <= bias_s;
      sta_r      <= sta_s;
    end
  end

endmodule

// File: tb/tb_conv_1st_loader.sv
// Randomized self-checking bench for conv_1st_loader; expected write streams
// are derived from the frame contents held in the bench.
module tb_conv_1st_loader;
  localparam int NUM_PIX  = 300;
  localparam int NUM_BIAS = 34;
  localparam int NWORDS   = NUM_PIX / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  pix_i = 8'd0;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic [15:0] bias_data_i = 16'd0;
  logic        bias_valid_i = 1'b0;
  logic        bias_ready_o;
  logic [39:0] scan_o;
  logic [23:0] bias_o;
  logic        busy_o;
  logic        sta_o;

  conv_1st_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .bias_data_i(bias_data_i), .bias_valid_i(bias_valid_i), .bias_ready_o(bias_ready_o),
    .scan_o(scan_o), .bias_o(bias_o), .busy_o(busy_o), .sta_o(sta_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Frame contents: the reference for every write the DUT should produce
  logic [15:0] bdat[NUM_BIAS];
  logic [7:0]  pdat[NUM_PIX];

  logic [39:0] scan_q[$];
  logic [23:0] bias_q[$];
  int sta_cnt = 0;
  int sta_cyc = -1;
  int viol = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_o[6:0] != 7'h7F) scan_q.push_back(scan_o);
      else if (scan_o[39:7] != 33'd0) viol++;
      if (scan_o[7] != 1'b0) viol++;
      if (bias_o[5:0] != 6'h3F) bias_q.push_back(bias_o);
      else if (bias_o[23:6] != 18'd0) viol++;
      if (bias_o[7:6] != 2'b00) viol++;
      if (pix_ready_o && bias_ready_o) viol++;
      if (sta_o) begin
        sta_cnt++;
        sta_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int k = 0; k < NUM_BIAS; k++) bdat[k] = 16'($urandom);
    for (int n = 0; n < NUM_PIX; n++) pdat[n] = 8'($urandom);
  endtask

  task automatic check_frame(input int nw, input int nb);
    logic [31:0] w32;
    logic [39:0] e40;
    logic [23:0] e24;
    check("scan_count", 64'(scan_q.size()), 64'(nw));
    check("bias_count", 64'(bias_q.size()), 64'(nb));
    check("invariants", 64'(viol), 64'd0);
    for (int w = 0; w < nw && w < scan_q.size(); w++) begin
      w32 = 32'(pdat[4*w]) + 32'(pdat[4*w+1]) * 32'd256
          + 32'(pdat[4*w+2]) * 32'd65536 + 32'(pdat[4*w+3]) * 32'd16777216;
      e40 = 40'(w32) * 40'd256 + 40'(w);
      check("scan_word", 64'(scan_q[w]), 64'(e40));
    end
    for (int k = 0; k < nb && k < bias_q.size(); k++) begin
      e24 = 24'(bdat[k]) * 24'd256 + 24'(k);
      check("bias_word", 64'(bias_q[k]), 64'(e24));
    end
  endtask

  // Drives one frame; starts and ends 1 time unit after a rising edge.
  task automatic send_frame(input bit gaps, input bit poke, input bit chain,
                            input bit skip_start, input int abort_at, input int rst_at);
    int k;
    int n;
    int guard;
    int last_hs;
    k = 0; n = 0; guard = 0; last_hs = -1;
    scan_q.delete(); bias_q.delete(); sta_cnt = 0; viol = 0;
    if (!skip_start) begin
      start_i = 1'b1;
      step();
      start_i = 1'b0;
    end
    while (k < NUM_BIAS && guard < 4000) begin
      bias_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bias_data_i  = bias_valid_i ? bdat[k] : 16'($urandom);
      @(negedge clk);
      if (bias_valid_i && bias_ready_o) k++;
      if (rst_at >= 0 && k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_scan", 64'(scan_o), 64'h7F);
        check("rst_bias", 64'(bias_o), 64'h3F);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ready", 64'({pix_ready_o, bias_ready_o, sta_o}), 64'd0);
        bias_valid_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        return;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    bias_valid_i = 1'b0;
    while (n < NUM_PIX && guard < 8000) begin
      if (abort_at >= 0 && n == abort_at + 1) begin
        abort_i = 1'b1;
        pix_valid_i = 1'b1;
        pix_i = pdat[n];
        @(negedge clk);
        check("abort_ready", 64'(pix_ready_o), 64'd0);
        step();
        abort_i = 1'b0;
        pix_valid_i = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_scan", 64'(scan_o), 64'h7F);
        check("abort_bias", 64'(bias_o), 64'h3F);
        repeat (5) step();
        check("abort_sta", 64'(sta_cnt), 64'd0);
        return;
      end
      pix_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_i = pix_valid_i ? pdat[n] : 8'($urandom);
      start_i = poke && ($urandom_range(0, 9) == 0);
      @(negedge clk);
      if (pix_valid_i && pix_ready_o) begin
        if (n == NUM_PIX - 1) last_hs = cyc;
        n++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    pix_valid_i = 1'b0;
    start_i = 1'b0;
    if (n < NUM_PIX) begin
      check("timeout", 64'd1, 64'd0);
      return;
    end
    start_i = poke;
    @(negedge clk);
    check("done_busy", 64'(busy_o), 64'd1);
    step();
    start_i = chain;
    @(negedge clk);
    check("sta_pulse", 64'(sta_o), 64'd1);
    check("sta_busy", 64'(busy_o), 64'd0);
    step();
    start_i = 1'b0;
    @(negedge clk);
    check("post_busy", 64'(busy_o), 64'(chain));
    check("post_bias_ready", 64'(bias_ready_o), 64'(chain));
    check("sta_count", 64'(sta_cnt), 64'd1);
    check("sta_latency", 64'(sta_cyc - last_hs), 64'd2);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check("idle_scan", 64'(scan_o), 64'h000000007F);
    check("idle_bias", 64'(bias_o), 64'h00003F);
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_sta", 64'(sta_o), 64'd0);
    check("idle_readies", 64'({pix_ready_o, bias_ready_o}), 64'd0);
    step();

    // Deterministic frame, back-to-back
    for (int k = 0; k < NUM_BIAS; k++) bdat[k] = 16'h1000 + 16'(k);
    for (int n = 0; n < NUM_PIX; n++) pdat[n] = 8'(n);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    check_frame(NWORDS, NUM_BIAS);
    if (scan_q.size() == NWORDS && bias_q.size() == NUM_BIAS) begin
      check("ptr0_word", 64'(scan_q[0][39:8]), 64'h03020100);
      check("ptr74_word", 64'(scan_q[74][39:8]), 64'h2B2A2928);
      check("bias33", 64'(bias_q[33][23:8]), 64'h1021);
    end else begin
      check("frame_sizes", 64'(scan_q.size()), 64'(NWORDS));
    end

    // Same frame with random gaps
    send_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    check_frame(NWORDS, NUM_BIAS);

    // start pulses while busy, then start in the sta cycle chains a new frame
    fill_random();
    send_frame(1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
    check_frame(NWORDS, NUM_BIAS);
    fill_random();
    send_frame(1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    check_frame(NWORDS, NUM_BIAS);

    // Abort after pixel 150, then a fresh frame
    fill_random();
    send_frame(1'b0, 1'b0, 1'b0, 1'b0, 150, -1);
    check_frame(37, NUM_BIAS);
    fill_random();
    send_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    check_frame(NWORDS, NUM_BIAS);

    // Async reset mid bias load, then a full frame
    fill_random();
    send_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, 10);
    fill_random();
    send_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    check_frame(NWORDS, NUM_BIAS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_1st_loader.md
Name: conv_1st_loader

Overview:
- Transmitter side of the first-layer convolution scan-chain and bias load interface.
- Accepts an 8-bit pixel stream and a 16-bit bias/quant-parameter stream over valid/ready.
- Packs pixels 4-per-word and drives pointer-addressed write words onto scan_o and bias_o.
- Pulses sta_o once a full frame (biases, then pixels) has been written into the convolution block's buffers.

Parameters:
- NUM_PIX, 300, pixels per frame; must be a multiple of 4 (elaboration error otherwise).
- NUM_BIAS, 34, bias-buffer entries (0-31 channel biases, 32 = rescale multiplier, 33 = shift).
- SCAN_IDLE, 7'h7F, scan pointer value meaning "no write".
- BIAS_IDLE, 6'h3F, bias pointer value meaning "no write".

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin loading one frame; sampled only in IDLE.
- abort_i  in  1  synchronous abort; return to IDLE.
- pix_i  in  8  pixel data.
- pix_valid_i  in  1  pixel valid.
- pix_ready_o  out  1  pixel ready.
- bias_data_i  in  16  bias/parameter data.
- bias_valid_i  in  1  bias valid.
- bias_ready_o  out  1  bias ready.
- scan_o  out  40  [39:8] packed word, [7] 0, [6:0] word pointer.
- bias_o  out  24  [23:8] bias data, [7:6] 0, [5:0] bias pointer.
- busy_o  out  1  high outside IDLE.
- sta_o  out  1  one-cycle start pulse to the convolution block.

Behaviour:
Reset values:
- FSM in IDLE; counters 0.
- scan_o = {32'b0, 1'b0, SCAN_IDLE}; bias_o = {16'b0, 2'b0, BIAS_IDLE}.
- pix_ready_o = bias_ready_o = busy_o = sta_o = 0.

FSM states and transitions:
- IDLE: start_i=1 -> LOAD_BIAS. Otherwise hold.
- LOAD_BIAS: bias_ready_o=1. A handshake (valid&ready) on bias index k registers bias_o = {bias_data_i, 2'b0, k[5:0]} for exactly the next cycle. On handshake k = NUM_BIAS-1 -> LOAD_PIX.
- LOAD_PIX: pix_ready_o=1. Handshake on pixel n writes pix_i into byte lane n%4 (lane 0 = bits [7:0] of the word, i.e. scan bits [15:8]). When lane 3 is accepted, scan_o = {word, 1'b0, n>>2} for exactly the next cycle. On handshake n = NUM_PIX-1 -> DONE.
- DONE: one cycle only; carries the final scan_o word. Then -> IDLE, with sta_o=1 in the first IDLE cycle.

Output and ready rules:
- In every cycle without a write, scan_o and bias_o return to their idle values (data fields zeroed). The receiver never sees a repeated pointer.
- Both readies are combinational from state only, never from valid. pix_ready_o and bias_ready_o are never high in the same cycle.
- Pixel word buffer is cleared on IDLE entry, so no stale bytes carry across frames.

Latency:
- Handshake in cycle T -> write word visible in T+1 -> receiver buffer updated at end of T+1.
- Last pixel at T: sta_o high at T+2; busy_o low from T+2.

Boundary conditions:
- Valid low: counters and lane index hold; gaps of any length allowed.
- start_i while busy: ignored.
- start_i in the same cycle sta_o is high: accepted, so FSM moves to LOAD_BIAS next cycle.
- abort_i (any non-IDLE state): next cycle IDLE, counters cleared, outputs idle, no sta_o. A write already registered in the abort cycle still completes. abort_i has priority over a handshake in the same cycle (data not accepted, ready forced 0 that cycle).
- Async reset mid-frame: immediate return to reset values; the partial frame is discarded.

Widths and counters:
- Pixel counter 9 bits, bias counter 6 bits, word pointer 7 bits.
- Pointers never reach the idle codes for default parameters (max 74 and 33).

Test Plan:
1. Reset, then idle 10 cycles -> scan_o=40'h000000007F, bias_o=24'h00003F, busy_o=0, sta_o=0, both readies 0.
2. start_i, biases 16'h1000+k for k=0..33 back-to-back, then pixels n[7:0] for n=0..299 -> bias_o pointer 33 carries 16'h1021; scan_o ptr 0 = 32'h03020100, ptr 74 = 32'h2B2A2928; exactly 75 scan writes; sta_o one cycle at last-pixel cycle+2.
3. Same frame with random valid gaps and 1-in-3 idle cycles -> identical write sequence (order, pointers, data) to scenario 2; only timing stretches.
4. start_i pulsed during LOAD_PIX and during DONE -> no effect; one sta_o total. start_i in the sta_o cycle -> LOAD_BIAS next cycle.
5. abort_i after pixel 150 (lane 2 of word 37) -> no write for word 37, idle outputs, no sta_o. A new frame then packs word 0 from fresh bytes.
6. rst_n asserted mid-LOAD_BIAS -> outputs at reset values asynchronously; after release, a full frame completes correctly.
